// File: rtl/stage_seq_pkg.sv
// Shared encodings for the decoder stage sequencer: hub command codes, status types, root FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package stage_seq_pkg;

   // Command word, bits[2:0]; upper bits are always zero
   localparam logic [2:0] CMD_ADVANCE    = 3'd1;
   localparam logic [2:0] CMD_FINISH     = 3'd2;   // also the abort-in-spread code
   localparam logic [2:0] CMD_ABORT_SYNC = 3'd3;

   // Status word, bits[2:0] = type, bit STS_FLAG_BIT = phase flag
   localparam logic [2:0] STS_SPREAD   = 3'd5;
   localparam logic [2:0] STS_SYNC     = 3'd6;
   localparam int         STS_FLAG_BIT = 3;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SEND_LOAD,
      ST_WAIT_SPREAD,
      ST_SEND_SYNC,
      ST_WAIT_SYNC,
      ST_SEND_GROW,
      ST_SEND_FINISH,
      ST_SEND_ABORT_SYNC,
      ST_SEND_ABORT_SPREAD
   } root_state_t;

endpackage

// File: rtl/stage_cmd_broadcaster.sv
// Broadcasts one command word to every leaf while go is high, tracking which leaves still owe a handshake.
// Latency: cmd_valid is all ones in the first go cycle; a leaf's valid drops the cycle after its handshake.
// Backpressure: each leaf stalls independently via cmd_ready; done is high in the cycle of the last handshake.
// Ports: clk/reset (async active-low); go/word from the root FSM; cmd_data/cmd_valid/cmd_ready per leaf; done.
module stage_cmd_broadcaster #(
   parameter int N_LEAVES       = 2,
   parameter int HUB_FIFO_WIDTH = 16
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               go,
   input  logic [HUB_FIFO_WIDTH-1:0]          word,
   output logic [N_LEAVES*HUB_FIFO_WIDTH-1:0] cmd_data,
   output logic [N_LEAVES-1:0]                cmd_valid,
   input  logic [N_LEAVES-1:0]                cmd_ready,
   output logic                               done
);

   logic                active;     // a broadcast is under way and pending is meaningful
   logic [N_LEAVES-1:0] pending;
   logic [N_LEAVES-1:0] pend_eff;

   // First cycle of a broadcast behaves as if every leaf is pending, so the
   // root can raise go and the command appears on the same cycle.
   always_comb begin
      pend_eff  = active ? pending : {N_LEAVES{1'b1}};
      cmd_valid = go ? pend_eff : '0;
      cmd_data  = go ? {N_LEAVES{word}} : '0;
      done      = go && ((pend_eff & ~cmd_ready) == '0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         active  <= 1'b0;
         pending <= '0;
      end else if (done || !go) begin
         active  <= 1'b0;
         pending <= '0;
      end else begin
         active  <= 1'b1;
         pending <= pend_eff & ~cmd_ready;
      end
   end

endmodule

// File: rtl/decoder_stage_sequencer_root.sv
// Root stage sequencer: broadcasts stage commands to N leaves, collects one status per leaf, steps spread/sync/grow.
// Latency: command issued on the edge entering SEND_*; state moves the cycle after the last handshake or status word.
// Backpressure: cmd_ready stalls the broadcast per leaf; sts_ready is low for leaves already heard from this pass.
// Ports: clk, reset (async active-low); start/busy; cmd_data/cmd_valid/cmd_ready and sts_data/sts_valid/sts_ready
//        per leaf (leaf i at slice i); result_valid, deadlock, iteration_counter, cycle_counter to the host.
// Optional: define STAGE_SEQ_TIMEOUT_EN to abort a WAIT_* phase after TIMEOUT_CYCLES cycles without full collection.
module decoder_stage_sequencer_root
   import stage_seq_pkg::*;
#(
   parameter int N_LEAVES                = 2,
   parameter int HUB_FIFO_WIDTH          = 16,
   parameter int ITERATION_COUNTER_WIDTH = 8,
   parameter int MAX_ITERATIONS          = 200,
   parameter int TIMEOUT_CYCLES          = 4096
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               start,
   output logic                               busy,
   output logic [N_LEAVES*HUB_FIFO_WIDTH-1:0] cmd_data,
   output logic [N_LEAVES-1:0]                cmd_valid,
   input  logic [N_LEAVES-1:0]                cmd_ready,
   input  logic [N_LEAVES*HUB_FIFO_WIDTH-1:0] sts_data,
   input  logic [N_LEAVES-1:0]                sts_valid,
   output logic [N_LEAVES-1:0]                sts_ready,
   output logic                               result_valid,
   output logic                               deadlock,
   output logic [ITERATION_COUNTER_WIDTH-1:0] iteration_counter,
   output logic [31:0]                        cycle_counter
);

   if (HUB_FIFO_WIDTH < 4 || N_LEAVES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("decoder_stage_sequencer_root: invalid parameter set");
   end

   root_state_t               state;
   logic [HUB_FIFO_WIDTH-1:0] cmd_word;
   logic [N_LEAVES-1:0]       received;
   logic                      flag_acc;
   logic [N_LEAVES-1:0]       rcv_nxt;
   logic                      flag_nxt;
   logic                      all_in;
   logic                      in_send;
   logic                      in_wait;
   logic                      bc_done;
   logic                      iter_cap;
   logic                      timeout_hit;
   logic [2:0]                exp_type;
   logic                      unused_sts;

   assign in_wait   = (state == ST_WAIT_SPREAD) || (state == ST_WAIT_SYNC);
   assign in_send   = state inside {ST_SEND_LOAD, ST_SEND_SYNC, ST_SEND_GROW, ST_SEND_FINISH,
                                    ST_SEND_ABORT_SYNC, ST_SEND_ABORT_SPREAD};
   assign busy      = (state != ST_IDLE);
   assign sts_ready = in_wait ? ~received : '0;
   assign exp_type  = (state == ST_WAIT_SYNC) ? STS_SYNC : STS_SPREAD;
   // Only the type and flag fields of a status word carry meaning
   assign unused_sts = ^sts_data;

   // The next grow would reach the iteration cap
   assign iter_cap = ({1'b0, iteration_counter} + 1'b1) >= (ITERATION_COUNTER_WIDTH+1)'(MAX_ITERATIONS);

   // Words of the wrong type are still popped (ready was high) but leave no trace
   always_comb begin
      rcv_nxt  = received;
      flag_nxt = flag_acc;
      for (int i = 0; i < N_LEAVES; i++) begin
         if (sts_valid[i] && sts_ready[i] &&
             sts_data[i*HUB_FIFO_WIDTH +: 3] == exp_type) begin
            rcv_nxt[i] = 1'b1;
            flag_nxt   = flag_nxt | sts_data[i*HUB_FIFO_WIDTH + STS_FLAG_BIT];
         end
      end
      all_in = in_wait && (&rcv_nxt);
   end

`ifdef STAGE_SEQ_TIMEOUT_EN
   localparam int PHASE_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [PHASE_W-1:0] phase_cnt;

   // Counts wait cycles that did not complete a collection; holds across a spread re-collect
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        phase_cnt <= '0;
      else if (!in_wait) phase_cnt <= '0;
      else if (!all_in)  phase_cnt <= phase_cnt + 1'b1;
   end

   assign timeout_hit = in_wait && !all_in && (phase_cnt == PHASE_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   stage_cmd_broadcaster #(
      .N_LEAVES       (N_LEAVES),
      .HUB_FIFO_WIDTH (HUB_FIFO_WIDTH)
   ) u_bcast (
      .clk       (clk),
      .reset     (reset),
      .go        (in_send),
      .word      (cmd_word),
      .cmd_data  (cmd_data),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .done      (bc_done)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state             <= ST_IDLE;
         cmd_word          <= '0;
         received          <= '0;
         flag_acc          <= 1'b0;
         result_valid      <= 1'b0;
         deadlock          <= 1'b0;
         iteration_counter <= '0;
         cycle_counter     <= '0;
      end else begin
         result_valid <= 1'b0;
         if (state != ST_IDLE && cycle_counter != '1)
            cycle_counter <= cycle_counter + 1'b1;

         case (state)
            ST_IDLE: if (start) begin
               deadlock          <= 1'b0;
               iteration_counter <= '0;
               cycle_counter     <= 32'd1;
               cmd_word          <= HUB_FIFO_WIDTH'(CMD_ADVANCE);
               state             <= ST_SEND_LOAD;
            end
            ST_SEND_LOAD, ST_SEND_GROW: if (bc_done) state <= ST_WAIT_SPREAD;
            ST_SEND_SYNC:               if (bc_done) state <= ST_WAIT_SYNC;
            ST_SEND_FINISH: if (bc_done) begin
               state        <= ST_IDLE;
               result_valid <= 1'b1;
            end
            ST_SEND_ABORT_SYNC, ST_SEND_ABORT_SPREAD: if (bc_done) begin
               state    <= ST_IDLE;
               deadlock <= 1'b1;
            end
            ST_WAIT_SPREAD: begin
               if (all_in) begin
                  // Messages still flying: stay and collect another pass
                  if (!flag_nxt) begin
                     cmd_word <= HUB_FIFO_WIDTH'(CMD_ADVANCE);
                     state    <= ST_SEND_SYNC;
                  end
               end else if (timeout_hit) begin
                  cmd_word <= HUB_FIFO_WIDTH'(CMD_FINISH);
                  state    <= ST_SEND_ABORT_SPREAD;
               end
            end
            ST_WAIT_SYNC: begin
               if (all_in) begin
                  if (!flag_nxt) begin
                     cmd_word <= HUB_FIFO_WIDTH'(CMD_FINISH);
                     state    <= ST_SEND_FINISH;
                  end else if (iter_cap) begin
                     cmd_word <= HUB_FIFO_WIDTH'(CMD_ABORT_SYNC);
                     state    <= ST_SEND_ABORT_SYNC;
                  end else begin
                     iteration_counter <= iteration_counter + 1'b1;
                     cmd_word          <= HUB_FIFO_WIDTH'(CMD_ADVANCE);
                     state             <= ST_SEND_GROW;
                  end
               end else if (timeout_hit) begin
                  cmd_word <= HUB_FIFO_WIDTH'(CMD_ABORT_SYNC);
                  state    <= ST_SEND_ABORT_SYNC;
               end
            end
            default: state <= ST_IDLE;
         endcase

         if (!in_wait || all_in) begin
            received <= '0;
            flag_acc <= 1'b0;
         end else begin
            received <= rcv_nxt;
            flag_acc <= flag_nxt;
         end
      end
   end

endmodule

// File: tb/tb_decoder_stage_sequencer_root.sv
// Bench for decoder_stage_sequencer_root: directed rounds plus random leaves against a protocol-level model.
// Latency: model advances on each rising edge; outputs compared on every falling edge.
// Backpressure: leaves stall commands via per-leaf hold counters or random ready.
module tb_decoder_stage_sequencer_root;
   localparam int N    = 2;
   localparam int W    = 16;
   localparam int IW   = 8;
   localparam int MAXI = 4;
   localparam int TO   = 16;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            start = 1'b0;
   logic            busy;
   logic [N*W-1:0]  cmd_data;
   logic [N-1:0]    cmd_valid;
   logic [N-1:0]    cmd_ready = '0;
   logic [N*W-1:0]  sts_data = '0;
   logic [N-1:0]    sts_valid = '0;
   logic [N-1:0]    sts_ready;
   logic            result_valid;
   logic            deadlock;
   logic [IW-1:0]   iteration_counter;
   logic [31:0]     cycle_counter;

   always #5 clk = ~clk;

   decoder_stage_sequencer_root #(
      .N_LEAVES(N), .HUB_FIFO_WIDTH(W), .ITERATION_COUNTER_WIDTH(IW),
      .MAX_ITERATIONS(MAXI), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy),
      .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .sts_data(sts_data), .sts_valid(sts_valid), .sts_ready(sts_ready),
      .result_valid(result_valid), .deadlock(deadlock),
      .iteration_counter(iteration_counter), .cycle_counter(cycle_counter)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- protocol model ----------------
   // mode: 0 idle, 1 broadcasting, 2 collecting. after: -1 result, -2 deadlock, 5/6 collect that status type.
   int          m_mode, m_cmd, m_after, m_wt, m_iter, m_wcnt;
   bit [N-1:0]  m_pend, m_got;
   bit          m_acc, m_dl, m_rv;
   logic [31:0] m_cyc;

   task automatic m_send(int c, int after);
      m_mode = 1; m_cmd = c; m_after = after; m_pend = '1;
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_mode = 0; m_cmd = 0; m_after = 0; m_wt = 5; m_iter = 0; m_wcnt = 0;
         m_pend = '0; m_got = '0; m_acc = 0; m_dl = 0; m_rv = 0; m_cyc = '0;
      end else begin
         m_rv = 0;
         if (m_mode != 0 && m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
         case (m_mode)
            0: if (start) begin m_dl = 0; m_iter = 0; m_cyc = 1; m_send(1, 5); end
            1: begin
               m_pend = m_pend & ~cmd_ready;
               if (m_pend == '0) begin
                  if (m_after == -1)      begin m_mode = 0; m_rv = 1; end
                  else if (m_after == -2) begin m_mode = 0; m_dl = 1; end
                  else begin m_mode = 2; m_wt = m_after; m_got = '0; m_acc = 0; m_wcnt = 0; end
               end
            end
            default: begin
               for (int i = 0; i < N; i++)
                  if (sts_valid[i] && !m_got[i] && int'(sts_data[i*W +: 3]) == m_wt) begin
                     m_got[i] = 1'b1;
                     m_acc = m_acc | sts_data[i*W + 3];
                  end
               if (&m_got) begin
                  m_got = '0;
                  if (m_wt == 5) begin
                     if (!m_acc) m_send(1, 6);
                  end else if (!m_acc)         m_send(2, -1);
                  else if (m_iter + 1 >= MAXI) m_send(3, -2);
                  else begin m_iter++; m_send(1, 5); end
                  m_acc = 0;
               end
`ifdef STAGE_SEQ_TIMEOUT_EN
               else begin
                  m_wcnt++;
                  if (m_wcnt == TO) m_send(m_wt == 5 ? 2 : 3, -2);
               end
`endif
            end
         endcase
      end
   end

   // ---------------- leaves ----------------
   logic [W-1:0] q0[$];
   logic [W-1:0] q1[$];
   bit [N-1:0]   hs, fq;
   int           hold[N];
   bit           force_low = 0, rnd_mode = 0, cnt_en = 0;
   int           cnt_v0 = 0, cnt_v1 = 0, rv_seen = 0, cmd_log = 0;

   function automatic logic [W-1:0] sw(int typ, bit flag);
      logic [W-1:0] w;
      w = W'($urandom);
      w[3:0] = {flag, 3'(typ)};
      return w;
   endfunction

   task automatic push(int i, int typ, bit flag);
      if (i == 0) q0.push_back(sw(typ, flag)); else q1.push_back(sw(typ, flag));
   endtask

   always begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
         int typ;
         if (hs[i] && fq[i]) begin
            if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
         end
         if (rnd_mode) cmd_ready[i] = ($urandom % 4) != 0;
         else          cmd_ready[i] = !(force_low || hold[i] > 0);
         if ((i == 0 ? q0.size() : q1.size()) > 0) begin
            fq[i] = 1; sts_valid[i] = 1;
            sts_data[i*W +: W] = (i == 0) ? q0[0] : q1[0];
         end else if (rnd_mode) begin
            fq[i] = 0; sts_valid[i] = ($urandom % 3) != 0;
            typ = (m_mode == 2) ? m_wt : 5;
            case ($urandom % 8)
               0:       typ = 7;
               1:       typ = 11 - typ;
               default: ;
            endcase
            sts_data[i*W +: W] = sw(typ, (typ == 5) ? (($urandom % 4) == 0) : (($urandom % 3) == 0));
         end else begin
            fq[i] = 0; sts_valid[i] = 0; sts_data[i*W +: W] = '0;
         end
      end
   end

   // ---------------- compare + bookkeeping ----------------
   logic [N-1:0] ev, er;
   always @(negedge clk) begin
      ev = (m_mode == 1) ? m_pend : '0;
      er = (m_mode == 2) ? ~m_got : '0;
      chk("busy", 64'(busy), 64'(m_mode != 0));
      chk("cmd_valid", 64'(cmd_valid), 64'(ev));
      for (int i = 0; i < N; i++)
         if (ev[i]) chk("cmd_data", 64'(cmd_data[i*W +: W]), 64'(m_cmd));
      chk("sts_ready", 64'(sts_ready), 64'(er));
      chk("result_valid", 64'(result_valid), 64'(m_rv));
      chk("deadlock", 64'(deadlock), 64'(m_dl));
      chk("iteration_counter", 64'(iteration_counter), 64'(m_iter));
      chk("cycle_counter", 64'(cycle_counter), 64'(m_cyc));
      hs = sts_valid & sts_ready;
      if (cmd_valid[0] && cmd_ready[0]) cmd_log = cmd_log * 10 + int'(cmd_data[2:0]);
      if (result_valid) rv_seen++;
      if (cnt_en) begin
         cnt_v0 += int'(cmd_valid[0]);
         cnt_v1 += int'(cmd_valid[1]);
         if (sts_ready != '0) cnt_en = 0;
      end
      for (int i = 0; i < N; i++)
         if (cmd_valid[i] && hold[i] > 0) hold[i]--;
   end

   // ---------------- directed helpers ----------------
   task automatic pulse_start();
      @(posedge clk); #1 start = 1;
      @(posedge clk); #1 start = 0;
   endtask

   task automatic wait_idle(string name, int budget);
      int n = 0;
      while (busy && n < budget) begin @(negedge clk); n++; end
      checks++;
      if (busy) begin
         errors++;
         $display("FAIL %s round did not end within %0d cycles", name, budget);
      end
      @(negedge clk);
   endtask

   task automatic pair(int i, int reps, bit sync_flag);
      for (int k = 0; k < reps; k++) begin push(i, 5, 0); push(i, 6, sync_flag); end
   endtask

   int rv0;

   initial begin
      hold[0] = 0; hold[1] = 0;
      #3;
      chk("reset_busy", 64'(busy), 0);
      chk("reset_cmd_valid", 64'(cmd_valid), 0);
      chk("reset_cycle", 64'(cycle_counter), 0);
      #10 reset = 1;

      // 1: plain round
      pair(0, 1, 0); pair(1, 1, 0);
      rv0 = rv_seen; cmd_log = 0;
      pulse_start(); wait_idle("t1", 200);
      chk("t1_result_pulses", 64'(rv_seen - rv0), 1);
      chk("t1_cmd_seq", 64'(cmd_log), 64'(112));
      chk("t1_iter", 64'(iteration_counter), 0);
      chk("t1_deadlock", 64'(deadlock), 0);

      // 2: three grows driven by leaf1's odd clusters
      pair(0, 4, 0); pair(1, 3, 1); pair(1, 1, 0);
      rv0 = rv_seen; cmd_log = 0;
      pulse_start(); wait_idle("t2", 400);
      chk("t2_iter", 64'(iteration_counter), 3);
      chk("t2_result_pulses", 64'(rv_seen - rv0), 1);
      chk("t2_cmd_seq", 64'(cmd_log), 64'(111111112));

      // 3: leaf0 stalls the load command for five cycles
      pair(0, 1, 0); pair(1, 1, 0);
      hold[0] = 5; cnt_v0 = 0; cnt_v1 = 0; cnt_en = 1;
      pulse_start(); wait_idle("t3", 200);
      chk("t3_leaf0_valid_cycles", 64'(cnt_v0), 6);
      chk("t3_leaf1_valid_cycles", 64'(cnt_v1), 1);

      // 4: iteration cap reached
      pair(0, 4, 1); pair(1, 4, 0);
      rv0 = rv_seen; cmd_log = 0;
      pulse_start(); wait_idle("t4", 400);
      chk("t4_deadlock", 64'(deadlock), 1);
      chk("t4_iter", 64'(iteration_counter), 3);
      chk("t4_result_pulses", 64'(rv_seen - rv0), 0);
      chk("t4_cmd_seq", 64'(cmd_log), 64'(111111113));
      pair(0, 1, 0); pair(1, 1, 0);
      pulse_start(); @(negedge clk);
      chk("t4_deadlock_cleared", 64'(deadlock), 0);
      wait_idle("t4b", 200);

`ifdef STAGE_SEQ_TIMEOUT_EN
      // 5: leaf1 never reports spread status
      push(0, 5, 0);
      cmd_log = 0;
      pulse_start(); wait_idle("t5", 200);
      chk("t5_deadlock", 64'(deadlock), 1);
      chk("t5_cmd_seq", 64'(cmd_log), 64'(12));
`endif

      // 6: reset during a stalled sync broadcast, then junk status words
      push(0, 5, 0); push(1, 5, 0);
      pulse_start();
      begin
         int n = 0;
         while (sts_ready == '0 && n < 50) begin @(negedge clk); n++; end
         force_low = 1;
         n = 0;
         while (cmd_valid != 2'b11 && n < 50) begin @(negedge clk); n++; end
         chk("t6_sync_broadcast_seen", 64'(cmd_valid), 64'(2'b11));
      end
      @(negedge clk); #2 reset = 0; #1;
      chk("t6_async_busy", 64'(busy), 0);
      chk("t6_async_cmd_valid", 64'(cmd_valid), 0);
      chk("t6_async_cmd_data", 64'(cmd_data), 0);
      chk("t6_async_cycle", 64'(cycle_counter), 0);
      force_low = 0;
      push(0, 7, 1); push(0, 5, 0); push(0, 6, 0);
      push(1, 5, 0); push(1, 7, 1); push(1, 6, 0);
      @(negedge clk); #2 reset = 1;
      rv0 = rv_seen;
      pulse_start(); wait_idle("t6", 200);
      chk("t6_result_pulses", 64'(rv_seen - rv0), 1);
      chk("t6_leaf0_drained", 64'(q0.size()), 0);
      chk("t6_leaf1_drained", 64'(q1.size()), 0);

      // random leaves and random start pulses, including starts while busy
      rnd_mode = 1;
      for (int c = 0; c < 4000; c++) begin
         @(posedge clk); #1 start = (($urandom % 12) == 0);
      end
      start = 0;
      repeat (4) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout bench did not complete");
      $fatal(1, "bench timeout");
   end

endmodule

// File: doc/decoder_stage_sequencer_root.md
Name: decoder_stage_sequencer_root

Overview:
Root scheduler that drives N leaf decoder stage controllers over their hub command/status links.
- Broadcasts stage-advance commands to every leaf.
- Collects one status word per leaf per phase and decides the next phase: spread → sync → grow loop, result, or abort.
- Sits on the hub side of the multi-FPGA decoder, one per decoding tree, and reports iteration/cycle counts and deadlock to the host.

Parameters:
N_LEAVES, 2, number of leaf stage controllers served.
HUB_FIFO_WIDTH, 16, width of each command/status word (≥4).
ITERATION_COUNTER_WIDTH, 8, iteration counter width.
MAX_ITERATIONS, 200, iteration cap; reaching it aborts.
TIMEOUT_CYCLES, 4096, watchdog limit per phase (only with the optional feature).

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begin a decode round (ignored unless IDLE)
busy  out  1  high in every state except IDLE
cmd_data  out  N_LEAVES*HUB_FIFO_WIDTH  per-leaf command word, leaf i at slice i
cmd_valid  out  N_LEAVES  per-leaf command valid
cmd_ready  in  N_LEAVES  per-leaf command ready
sts_data  in  N_LEAVES*HUB_FIFO_WIDTH  per-leaf status word
sts_valid  in  N_LEAVES  per-leaf status valid
sts_ready  out  N_LEAVES  per-leaf status ready
result_valid  out  1  one-cycle pulse: round finished normally
deadlock  out  1  sticky abort flag, cleared by start
iteration_counter  out  ITERATION_COUNTER_WIDTH  completed grow iterations this round
cycle_counter  out  32  cycles since start

Behaviour:
Encodings:
- Command word, bits[2:0]:
  - 1 = ADVANCE
  - 2 = FINISH/ABORT_IN_SPREAD
  - 3 = ABORT_IN_SYNC
  - upper bits zero.
- Status word:
  - bits[2:0] = 5 SPREAD_STS or 6 SYNC_STS
  - bit3 = flag: SPREAD_STS means messages flying; SYNC_STS means odd cluster present.
- Any other type is popped and discarded.

Reset (reset=0, async): state IDLE, all outputs 0, masks and accumulators cleared. Reset mid-broadcast drops the broadcast immediately.

Broadcast rule:
- On entering a SEND_* state, cmd_valid = all ones and cmd_data is the same word on every slice.
- Leaf i's valid drops the cycle after cmd_valid[i] & cmd_ready[i].
- The state exits the cycle after the last leaf handshakes.
- Leaves may accept in any order or simultaneously.

Collect rule:
- sts_ready[i] = 1 while in a WAIT_* state and received[i] = 0.
- A matching-type word sets received[i] and ORs its flag into flag_acc.
- When received is all ones: evaluate, then clear received and flag_acc.
- A second word from a leaf already received in the same pass is not accepted (ready low).

States:
- IDLE: on start, clear deadlock and iteration_counter, set cycle_counter = 1, go SEND_LOAD (ADVANCE).
- SEND_LOAD → WAIT_SPREAD.
- WAIT_SPREAD, on full collection:
  - flag_acc = 1: stay and re-collect.
  - otherwise go SEND_SYNC (ADVANCE).
- SEND_SYNC → WAIT_SYNC.
- WAIT_SYNC, on full collection:
  - flag_acc = 0: go SEND_FINISH (cmd 2).
  - otherwise, if iteration_counter+1 ≥ MAX_ITERATIONS: go SEND_ABORT_SYNC (cmd 3).
  - otherwise iteration_counter += 1 and go SEND_GROW (ADVANCE).
- SEND_GROW → WAIT_SPREAD.
- SEND_FINISH → IDLE, with a result_valid pulse on the exit cycle.
- SEND_ABORT_SYNC / SEND_ABORT_SPREAD (cmd 2 from WAIT_SPREAD) → IDLE with deadlock = 1, no result_valid.

Counters:
- cycle_counter increments every non-IDLE cycle and holds in IDLE; it saturates at 2^32−1.
- iteration_counter holds after the round until the next start.
- start while busy is ignored.

Optional Feature:
STAGE_SEQ_TIMEOUT_EN:
- Defined: a phase counter clears on every WAIT_* entry and increments each WAIT_* cycle. When it reaches TIMEOUT_CYCLES, go to SEND_ABORT_SPREAD (from WAIT_SPREAD) or SEND_ABORT_SYNC (from WAIT_SYNC).
- Undefined: no counter; WAIT_* waits indefinitely; deadlock is set only by MAX_ITERATIONS.

Decomposition:
- Shared package stage_seq_pkg holds:
  - command codes (CMD_ADVANCE=1, CMD_FINISH=2, CMD_ABORT_SYNC=3)
  - status types (STS_SPREAD=5, STS_SYNC=6)
  - STS_FLAG_BIT=3
  - the root state enum.
- One sub-module, stage_cmd_broadcaster: holds the per-leaf pending mask, drives cmd_valid, and asserts done when the mask empties. Parameters are N_LEAVES and HUB_FIFO_WIDTH.

Test Plan:
1. N_LEAVES=2, start, both leaves ready → cmd 1 to both; then SPREAD_STS flag0 ×2, SYNC_STS flag0 ×2 → cmd 1 (sync), cmd 2 (finish); result_valid one pulse; iteration_counter=0; deadlock=0.
2. SYNC_STS flag1 from leaf1 on passes 1–3, then flag0 → three ADVANCE grows; iteration_counter=3; then cmd 2 and result_valid.
3. Leaf0 cmd_ready held low 5 cycles while leaf1 accepts immediately → leaf1 valid drops after 1 cycle, leaf0 valid stays up 6 cycles; state advances only after leaf0 handshakes.
4. MAX_ITERATIONS=4 with odd clusters always reported → cmd 3 issued after iteration_counter=3; deadlock=1; no result_valid; next start clears deadlock.
5. With STAGE_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, leaf1 never sends SPREAD_STS → cmd 2 to both leaves after 16 wait cycles; deadlock=1.
6. reset driven low mid-SEND_SYNC with cmd_valid=2'b11 → outputs 0 asynchronously; IDLE after release; status type 7 words popped and ignored.
